// File: rtl/i2s_ws_ctrl.sv
// I2S word-select controller: tracks L/R slots and bit position in master or slave
// timing, generates shift-register load and frame strobes, and flags framing errors.
module i2s_ws_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_tick,
    input  logic       ws_in,
    input  logic [1:0] standard,
    input  logic [1:0] mode,
    input  logic       frame_size,
    input  logic       stereo,
    input  logic       stop,
    output logic       ws_out,
    output logic [1:0] state,
    output logic [4:0] bit_idx,
    output logic       ld_pulse,
    output logic       frame_done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_L    = 2'b01,
        ST_R    = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    state_t     state_r, state_s;
    logic [4:0] bit_idx_r, idx_s;
    logic       ws_out_r, ws_s;
    logic       ld_r, ld_s;
    logic       fd_r, fd_s;
    logic       err_r, err_s;

    logic [1:0] sh_std_r;
    logic       sh_master_r;
    logic       sh_fs_r;
    logic       sh_stereo_r;

    logic       ws_prev_r;
    logic       edge_d_r;
    logic       fall_d_r;
    logic       stop_pend_r;

    logic [4:0] last_idx_s;
    logic [4:0] pre_idx_s;
    logic       is_i2s_s;
    logic       illegal_s;
    logic       edge_s;
    logic       ev_s;
    logic       ev_fall_s;
    logic       stop_any_s;
    logic       slot_end_s;
    logic       fault_s;
    logic       r_end_s;
    logic       cur_slot_s;
    logic       nxt_slot_s;

    assign last_idx_s = sh_fs_r ? 5'd31 : 5'd15;
    assign pre_idx_s  = sh_fs_r ? 5'd30 : 5'd14;
    assign is_i2s_s   = (sh_std_r == 2'b00);
    assign illegal_s  = (sh_std_r == 2'b11);
    assign edge_s     = (ws_in != ws_prev_r);
    // I2S slots begin one tick after the ws edge, so use the edge recorded on the previous tick
    assign ev_s       = is_i2s_s ? edge_d_r : edge_s;
    assign ev_fall_s  = is_i2s_s ? fall_d_r : ~ws_in;
    assign stop_any_s = stop | stop_pend_r;
    assign cur_slot_s = (state_r == ST_L) || (state_r == ST_R);
    assign nxt_slot_s = (state_s == ST_L) || (state_s == ST_R);

    // Next-state, bit counter and strobe decode, evaluated only on serial ticks
    always_comb begin
        state_s    = state_r;
        idx_s      = bit_idx_r;
        ws_s       = ws_out_r;
        ld_s       = 1'b0;
        fd_s       = 1'b0;
        err_s      = 1'b0;
        r_end_s    = 1'b0;
        slot_end_s = 1'b0;
        fault_s    = 1'b0;
        if (sck_tick) begin
            case (state_r)
                ST_IDLE: begin
                    idx_s = 5'd0;
                    if (stop) begin
                        state_s = ST_IDLE;
                    end else if (illegal_s) begin
                        fault_s = 1'b1;
                    end else if (sh_master_r || (ev_s && ev_fall_s)) begin
                        state_s = ST_L;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_L, ST_R: begin
                    if (illegal_s) begin
                        fault_s = 1'b1;
                    end else if (sh_master_r || ev_s) begin
                        if (bit_idx_r == last_idx_s) begin
                            slot_end_s = 1'b1;
                        end else if (sh_master_r) begin
                            idx_s = bit_idx_r + 5'd1;
                        end else begin
                            fault_s = 1'b1;
                        end
                    end else if (bit_idx_r == last_idx_s) begin
                        fault_s = 1'b1;
                    end else begin
                        idx_s = bit_idx_r + 5'd1;
                    end
                    if (slot_end_s) begin
                        idx_s = 5'd0;
                        if (state_r == ST_L) begin
                            state_s = ST_R;
                        end else begin
                            fd_s    = 1'b1;
                            r_end_s = 1'b1;
                            state_s = stop_any_s ? ST_IDLE : ST_L;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ERR: begin
                    idx_s = 5'd0;
                    if (stop) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ERR;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = 5'd0;
                end
            endcase

            if (fault_s) begin
                state_s = ST_ERR;
                idx_s   = 5'd0;
                err_s   = 1'b1;
                fd_s    = 1'b0;
                r_end_s = 1'b0;
            end else begin
                err_s = 1'b0;
            end

            // I2S leads the slot change by one bit; MSB/LSB follow the slot directly
            if (nxt_slot_s && sh_master_r) begin
                if (!is_i2s_s) begin
                    ws_s = (state_s == ST_R);
                end else if (cur_slot_s && (bit_idx_r == pre_idx_s)) begin
                    ws_s = (state_r == ST_L);
                end else begin
                    ws_s = ws_out_r;
                end
            end else begin
                ws_s = 1'b0;
            end

            if (nxt_slot_s && (sh_stereo_r || (state_s == ST_L))) begin
                if (is_i2s_s) begin
                    ld_s = (idx_s == 5'd1);
                end else begin
                    ld_s = (idx_s == 5'd0) && (state_s != state_r);
                end
            end else begin
                ld_s = 1'b0;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_idx_r <= 5'd0;
            ws_out_r  <= 1'b0;
            ld_r      <= 1'b0;
            fd_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_idx_r <= idx_s;
            ws_out_r  <= ws_s;
            ld_r      <= ld_s;
            fd_r      <= fd_s;
            err_r     <= err_s;
        end
    end

    // Config shadow: open while idle and at each frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_std_r    <= 2'b00;
            sh_master_r <= 1'b0;
            sh_fs_r     <= 1'b0;
            sh_stereo_r <= 1'b0;
        end else if ((state_r == ST_IDLE) || r_end_s) begin
            sh_std_r    <= standard;
            sh_master_r <= mode[1];
            sh_fs_r     <= frame_size;
            sh_stereo_r <= stereo;
        end else begin
            sh_std_r    <= sh_std_r;
            sh_master_r <= sh_master_r;
            sh_fs_r     <= sh_fs_r;
            sh_stereo_r <= sh_stereo_r;
        end
    end

    // ws_in history and delayed edge for I2S, plus stop request held until frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_prev_r   <= 1'b0;
            edge_d_r    <= 1'b0;
            fall_d_r    <= 1'b0;
            stop_pend_r <= 1'b0;
        end else begin
            if (sck_tick) begin
                ws_prev_r <= ws_in;
                edge_d_r  <= edge_s;
                fall_d_r  <= ~ws_in;
            end else begin
                ws_prev_r <= ws_prev_r;
                edge_d_r  <= edge_d_r;
                fall_d_r  <= fall_d_r;
            end
            if (cur_slot_s && nxt_slot_s) begin
                stop_pend_r <= stop_pend_r | stop;
            end else begin
                stop_pend_r <= 1'b0;
            end
        end
    end

    assign state      = state_r;
    assign bit_idx    = bit_idx_r;
    assign ws_out     = ws_out_r;
    assign ld_pulse   = ld_r;
    assign frame_done = fd_r;
    assign err        = err_r;

endmodule
